// File: rtl/fft_stage1_feeder.sv
// First-stage feeder for a radix-2 DIF FFT.
// Buffers one frame of N complex samples, then issues the N/2 operand pairs
// (x[k], x[k+N/2]) with twiddle index k to the butterfly.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FILL  | accepting samples into the frame buffer, sample_ready=1
// S_ISSUE | presenting operand pairs from the buffer, pair_valid=1
module fft_stage1_feeder #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 16,
  localparam int ADDR_W  = $clog2(N_POINTS),
  localparam int IDX_W   = (ADDR_W > 1) ? ADDR_W - 1 : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_real,
  input  logic [DATA_W-1:0] sample_imag,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [DATA_W-1:0] in1_real,
  output logic [DATA_W-1:0] in1_imag,
  output logic [DATA_W-1:0] in2_real,
  output logic [DATA_W-1:0] in2_imag,
  output logic [IDX_W-1:0]  twiddle_idx,
  output logic              frame_done
);

  typedef enum logic {S_FILL, S_ISSUE} state_t;

  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0]  LAST_K  = IDX_W'(N_POINTS / 2 - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   mem_re_q [N_POINTS];
  logic [DATA_W-1:0]   mem_re_d [N_POINTS];
  logic [DATA_W-1:0]   mem_im_q [N_POINTS];
  logic [DATA_W-1:0]   mem_im_d [N_POINTS];

  // Pair addresses: k in the lower half, k+N/2 is k with the top address bit set.
  logic [ADDR_W-1:0]   lo_addr;
  logic [ADDR_W-1:0]   hi_addr;
  assign lo_addr = {1'b0, k_q};
  assign hi_addr = {1'b1, k_q};

  // Next-state logic: flush overrides both handshakes; counters stop at their bounds.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    k_d          = k_q;
    frame_done_d = 1'b0;
    mem_re_d     = mem_re_q;
    mem_im_d     = mem_im_q;
    if (flush) begin
      state_d  = S_FILL;
      wr_cnt_d = '0;
      k_d      = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (sample_valid) begin
            mem_re_d[wr_cnt_q] = sample_real;
            mem_im_d[wr_cnt_q] = sample_imag;
            if (wr_cnt_q == LAST_WR) begin
              state_d  = S_ISSUE;
              wr_cnt_d = '0;
              k_d      = '0;
            end else begin
              wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (pair_ready) begin
            if (k_q == LAST_K) begin
              state_d      = S_FILL;
              k_d          = '0;
              frame_done_d = 1'b1;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // State, counters, frame buffer and done pulse; reset clears the buffer too.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_FILL;
      wr_cnt_q     <= '0;
      k_q          <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      k_q          <= k_d;
      frame_done_q <= frame_done_d;
      mem_re_q     <= mem_re_d;
      mem_im_q     <= mem_im_d;
    end
  end

  // Handshake flags decode only the registered state.
  assign sample_ready = (state_q == S_FILL);
  assign pair_valid   = (state_q == S_ISSUE);

  assign in1_real    = mem_re_q[lo_addr];
  assign in1_imag    = mem_im_q[lo_addr];
  assign in2_real    = mem_re_q[hi_addr];
  assign in2_imag    = mem_im_q[hi_addr];
  assign twiddle_idx = k_q;
  assign frame_done  = frame_done_q;

endmodule
